spi_slave_mlf_cs: RTL
=====================

Name: spi_slave_mlf_cs

Overview:
SPI slave that sits directly downstream of the team's single-CS SPI master on the SPI bus. It receives MOSI bytes and returns preloaded bytes on MISO, all in the system clock domain. SCLK, CS_n and MOSI are oversampled through synchronizers, so the bus is treated as asynchronous input. The byte-level interface matches the master's TX/RX DV style, so the two can be looped back on one bench.

Parameters:
SPI_MODE, 0, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; values 0..3.
MAX_BYTES_PER_CS, 2, saturation limit of o_RX_count within one CS frame.
SYNC_STAGES, 2, synchronizer depth on SCLK, CS_n and MOSI (minimum 2).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_TX_Byte  in  8  next byte to return on MISO
i_TX_DV  in  1  i_TX_Byte valid; accepted only when o_TX_Ready=1
o_TX_Ready  out  1  TX holding register empty
o_RX_DV  out  1  one-cycle pulse, o_RX_Byte valid
o_RX_Byte  out  8  last complete received byte
o_RX_count  out  $clog2(MAX_BYTES_PER_CS+1)  bytes received in the current or last CS frame
o_Frame_Err  out  1  one-cycle pulse when CS deasserts mid-byte
i_SPI_clk  in  1  SCLK from the master
i_SPI_CS_n  in  1  chip select, active-low
i_SPI_MOSI  in  1  master-out data
o_SPI_MISO  out  1  slave-out data
o_SPI_MISO_en  out  1  MISO driver enable (synchronized CS active)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n. All state updates on the rising edge of i_clk.
- Reset values:
  - o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_RX_count=0, o_Frame_Err=0, o_SPI_MISO=0, o_SPI_MISO_en=0.
  - Synchronizer flops reset to SCLK=CPOL, CS_n=1, MOSI=0.
- Timing constraint: each SCLK half-period must be at least SYNC_STAGES+2 i_clk cycles (4 with the default parameters). Any master clocked from i_clk must therefore use CLKS_PER_HALF_BIT≥4.
- Edges:
  - Leading SCLK edge is the rising edge when CPOL=0, the falling edge when CPOL=1.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- FSM:
  - IDLE to SHIFT on a detected synchronized CS falling edge. Clear the bit counter and o_RX_count, load the TX shift register from holding, and drive its MSB on MISO.
  - SHIFT to IDLE on a synchronized CS rising edge. If the bit counter is nonzero, pulse o_Frame_Err and discard the partial byte.
  - After reset, if CS is already low, stay in IDLE until CS is seen high then low.
- RX path:
  - MSB-first shift on each sample edge.
  - On the 8th sample: o_RX_Byte is updated and o_RX_DV pulses in the following cycle. o_RX_count increments, saturating at MAX_BYTES_PER_CS (bytes beyond it are still delivered). The bit counter wraps to 0.
  - o_RX_count holds after CS rise until the next CS fall.
- TX path:
  - i_TX_DV & o_TX_Ready loads the holding register; o_TX_Ready drops the next cycle.
  - At each byte boundary (CS fall, or 8th sample while CS is still low), holding moves to the shift register and o_TX_Ready returns high the next cycle.
  - If holding is empty at a boundary, shift out 0x00.
  - A write in the same cycle as a boundary does not reach that byte; it stays in holding for the next byte.
  - For CPHA=0, the next byte's MSB is driven on the trailing edge after bit 0. For CPHA=1, it is driven on the first leading edge.
- o_SPI_MISO_en equals the synchronized CS active. o_SPI_MISO is 0 when not enabled.

Decomposition:
- Package spi_mlf_pkg:
  - CPOL/CPHA decode functions.
  - TX fill byte constant 8'h00.
  - FSM state encoding (IDLE, SHIFT).
- Sub-module spi_mlf_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, with a parameterized reset value. Instantiated three times (SCLK, CS_n, MOSI; MOSI uses the level only).

Test Plan:
1. Mode 0, CLKS_PER_HALF_BIT=4, preload 0xA5, master sends 0x66 -> one o_RX_DV pulse, o_RX_Byte=0x66, master receives 0xA5, o_RX_count=1.
2. One CS frame, master sends 0x66 then 0xC2, slave preloads 0x3C then 0x81 -> RX 0x66 then 0xC2, o_RX_count=2, master sees 0x3C then 0x81.
3. No preload, master sends 0xC2 -> MISO shifts 0x00, o_TX_Ready stays 1, o_RX_Byte=0xC2.
4. CS deasserted after 5 bits, then a new frame carrying 0x5A -> no o_RX_DV in the first frame, one o_Frame_Err pulse, second frame gives o_RX_Byte=0x5A, o_RX_count=1.
5. Repeat scenario 1 in modes 1, 2 and 3 -> identical byte results in every mode.
6. i_rst_n low for 3 cycles mid-byte with CS held low -> all outputs at reset values, no o_RX_DV until CS goes high then low, then 0x66 is received correctly.

Source files
------------

// File: rtl/spi_mlf_pkg.sv
// Shared definitions for the oversampling SPI slave.
//   spi_cpol / spi_cpha : decode the SPI mode number into clock polarity / phase
//   TxFillByte          : byte shifted out when no TX byte has been preloaded
//   spi_state_e         : frame-level FSM encoding
package spi_mlf_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } spi_state_e;

    localparam logic [7:0] TxFillByte = 8'h00;

    function automatic logic spi_cpol(input int unsigned mode);
        return ((mode / 2) % 2) == 1;
    endfunction

    function automatic logic spi_cpha(input int unsigned mode);
        return (mode % 2) == 1;
    endfunction

endpackage

// File: rtl/spi_mlf_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, with rise/fall detection on the
// synchronized level. All flops reset to RESET_VAL, so an idle line reports no edge
// coming out of reset.
// Ports:
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_async        : asynchronous input line
//   o_level        : synchronized level
//   o_rise, o_fall : one-cycle pulses on synchronized transitions
module spi_mlf_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_mlf_cs.sv
// SPI slave clocked entirely from i_clk; SCLK, CS_n and MOSI are oversampled.
// Receives MOSI bytes MSB first and returns preloaded bytes on MISO.
// Ports:
//   i_clk, i_rst_n            : system clock, synchronous active-low reset
//   i_TX_Byte, i_TX_DV        : byte to return on MISO, accepted when o_TX_Ready=1
//   o_TX_Ready                : TX holding register empty
//   o_RX_DV, o_RX_Byte        : one-cycle valid pulse with last complete received byte
//   o_RX_count                : bytes received in current/last frame (saturating)
//   o_Frame_Err               : one-cycle pulse when CS rises mid-byte
//   i_SPI_clk, i_SPI_CS_n,
//   i_SPI_MOSI                : SPI bus inputs from the master
//   o_SPI_MISO, o_SPI_MISO_en : slave data out and its driver enable
module spi_slave_mlf_cs
    import spi_mlf_pkg::*;
#(
    parameter int unsigned SPI_MODE         = 0,
    parameter int unsigned MAX_BYTES_PER_CS = 2,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [7:0]                            i_TX_Byte,
    input  logic                                  i_TX_DV,
    output logic                                  o_TX_Ready,
    output logic                                  o_RX_DV,
    output logic [7:0]                            o_RX_Byte,
    output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_count,
    output logic                                  o_Frame_Err,
    input  logic                                  i_SPI_clk,
    input  logic                                  i_SPI_CS_n,
    input  logic                                  i_SPI_MOSI,
    output logic                                  o_SPI_MISO,
    output logic                                  o_SPI_MISO_en
);

    localparam logic              Cpol   = spi_cpol(SPI_MODE);
    localparam logic              Cpha   = spi_cpha(SPI_MODE);
    localparam int unsigned       CntW   = $clog2(MAX_BYTES_PER_CS + 1);
    localparam logic [CntW-1:0]   MaxCnt = CntW'(MAX_BYTES_PER_CS);

    // Synchronized bus
    logic w_unused_sclk_level;
    logic w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_mlf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(Cpol)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_SPI_clk),
        .o_level (w_unused_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_mlf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_SPI_CS_n),
        .o_level (w_cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_mlf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_SPI_MOSI),
        .o_level (w_mosi),
        .o_rise  (w_unused_mosi_rise),
        .o_fall  (w_unused_mosi_fall)
    );

    logic w_leading, w_trailing, w_sample_edge, w_shift_edge;
    assign w_leading     = Cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trailing    = Cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = Cpha ? w_trailing : w_leading;
    assign w_shift_edge  = Cpha ? w_leading  : w_trailing;

    // State
    spi_state_e             r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_armed, w_armed_d;
    logic [2:0]             r_bit_cnt, w_bit_cnt_d;
    logic [7:0]             r_rx_shift, w_rx_shift_d;
    logic [7:0]             r_rx_byte, w_rx_byte_d;
    logic                   r_rx_dv, w_rx_dv_d;
    logic [CntW-1:0]        r_rx_count, w_rx_count_d;
    logic                   r_frame_err, w_frame_err_d;
    logic [7:0]             r_tx_shift, w_tx_shift_d;
    logic                   r_miso, w_miso_d;
    logic [7:0]             r_tx_hold, w_tx_hold_d;
    logic                   r_hold_valid, w_hold_valid_d;

    logic       w_settled;
    logic       w_boundary;
    logic       w_tx_write;
    logic [7:0] w_next_byte;
    logic [7:0] w_rx_full;

    // The CS synchronizer output is only trustworthy once the reset value has been flushed.
    // A frame may start only after CS has been seen high on real samples, so a CS held
    // low through reset is not mistaken for a new frame.
    assign w_settled   = r_settle[SYNC_STAGES-1];
    assign w_tx_write  = i_TX_DV & ~r_hold_valid;
    assign w_next_byte = r_hold_valid ? r_tx_hold : TxFillByte;
    assign w_rx_full   = {r_rx_shift[6:0], w_mosi};

    always_comb begin
        w_state_d      = r_state;
        w_armed_d      = r_armed | (w_settled & w_cs_n);
        w_bit_cnt_d    = r_bit_cnt;
        w_rx_shift_d   = r_rx_shift;
        w_rx_byte_d    = r_rx_byte;
        w_rx_dv_d      = 1'b0;
        w_rx_count_d   = r_rx_count;
        w_frame_err_d  = 1'b0;
        w_tx_shift_d   = r_tx_shift;
        w_miso_d       = r_miso;
        w_tx_hold_d    = r_tx_hold;
        w_hold_valid_d = r_hold_valid;
        w_boundary     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_armed && w_cs_fall) begin
                    w_state_d    = StShift;
                    w_bit_cnt_d  = 3'd0;
                    w_rx_count_d = '0;
                    w_boundary   = 1'b1;
                    w_miso_d     = w_next_byte[7];
                    // CPHA=0 has the MSB on the wire already; the first shift edge drives bit 6.
                    // CPHA=1 re-drives the MSB on the first leading edge.
                    w_tx_shift_d = Cpha ? w_next_byte : {w_next_byte[6:0], 1'b0};
                end
            end
            StShift: begin
                if (w_cs_rise) begin
                    w_state_d     = StIdle;
                    w_frame_err_d = (r_bit_cnt != 3'd0);
                    w_bit_cnt_d   = 3'd0;
                    w_miso_d      = 1'b0;
                end else begin
                    if (w_shift_edge) begin
                        w_miso_d     = r_tx_shift[7];
                        w_tx_shift_d = {r_tx_shift[6:0], 1'b0};
                    end
                    if (w_sample_edge) begin
                        w_rx_shift_d = w_rx_full;
                        w_bit_cnt_d  = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_byte_d = w_rx_full;
                            w_rx_dv_d   = 1'b1;
                            if (r_rx_count != MaxCnt) begin
                                w_rx_count_d = r_rx_count + 1'b1;
                            end
                            w_boundary   = 1'b1;
                            w_tx_shift_d = w_next_byte;
                        end
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        // A write landing on a boundary cycle sees an empty holding register and stays
        // there for the following byte.
        if (w_tx_write) begin
            w_tx_hold_d = i_TX_Byte;
        end
        if (w_boundary) begin
            w_hold_valid_d = w_tx_write;
        end else if (w_tx_write) begin
            w_hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_settle     <= '0;
            r_armed      <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_rx_byte    <= 8'h00;
            r_rx_dv      <= 1'b0;
            r_rx_count   <= '0;
            r_frame_err  <= 1'b0;
            r_tx_shift   <= 8'h00;
            r_miso       <= 1'b0;
            r_tx_hold    <= 8'h00;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_settle     <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_armed      <= w_armed_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_rx_shift   <= w_rx_shift_d;
            r_rx_byte    <= w_rx_byte_d;
            r_rx_dv      <= w_rx_dv_d;
            r_rx_count   <= w_rx_count_d;
            r_frame_err  <= w_frame_err_d;
            r_tx_shift   <= w_tx_shift_d;
            r_miso       <= w_miso_d;
            r_tx_hold    <= w_tx_hold_d;
            r_hold_valid <= w_hold_valid_d;
        end
    end

    assign o_TX_Ready    = ~r_hold_valid;
    assign o_RX_DV       = r_rx_dv;
    assign o_RX_Byte     = r_rx_byte;
    assign o_RX_count    = r_rx_count;
    assign o_Frame_Err   = r_frame_err;
    assign o_SPI_MISO_en = ~w_cs_n;
    assign o_SPI_MISO    = r_miso & ~w_cs_n;

endmodule
